traffic_density_ctrl: RTL and testbench
=======================================

Name: traffic_density_ctrl

Overview:
- Upstream feeder of the traffic-light FSM: turns per-frame vehicle counts from the video-processing pipeline into the FSM's `traffic_sel`, `howmany_count_red` and `howmany_count_green` inputs.
- Averages counts over a window of frames and classifies LOW/HIGH density with hysteresis.
- Commits a new decision to its outputs only on the FSM's `tr_valid` pulse, so phase durations never change while a phase is counting.

Parameters:
- WIN_LOG2, 2, log2 of frames per averaging window (window = 4 frames)
- CNT_W, 8, width of per-frame vehicle count
- TH_HIGH, 20, average >= TH_HIGH moves LOW -> HIGH
- TH_LOW, 12, average <= TH_LOW moves HIGH -> LOW (TH_LOW < TH_HIGH required)
- RED_T_LOW, 10, red seconds when LOW (5-bit)
- GREEN_T_LOW, 10, green seconds when LOW (5-bit)
- RED_T_HIGH, 5, red seconds when HIGH (5-bit)
- GREEN_T_HIGH, 20, green seconds when HIGH (5-bit)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- frame_valid  in  1  one-cycle pulse: car_count valid, end of frame
- car_count  in  CNT_W  vehicles detected in the frame
- tr_valid  in  1  one-cycle pulse from FSM, first RED cycle after UPDATE
- traffic_sel  out  1  0 = LOW density, 1 = HIGH density
- howmany_count_red  out  5  red duration for FSM
- howmany_count_green  out  5  green duration for FSM
- density_avg  out  CNT_W  last computed window average
- decision_pending  out  1  level_reg differs from committed traffic_sel

Behaviour:
- Reset (reset == 0 at clk edge):
  - traffic_sel = 0, counts = RED_T_LOW / GREEN_T_LOW, density_avg = 0, decision_pending = 0.
  - Internal: acc = 0, frm_cnt = 0, level_reg = LOW, state = ACCUM.
  - Reset mid-window discards the partial sum.
- Accumulator: width CNT_W+WIN_LOG2 (no overflow possible). frm_cnt is WIN_LOG2 bits and wraps naturally.
- FSM states: ACCUM, EVAL.
- ACCUM, on frame_valid:
  - acc <= acc + car_count; frm_cnt <= frm_cnt + 1.
  - If frm_cnt == 2^WIN_LOG2 - 1, go to EVAL.
- EVAL (exactly one cycle):
  - avg = acc >> WIN_LOG2 (truncating); density_avg <= avg.
  - Hysteresis: LOW and avg >= TH_HIGH -> level_reg <= HIGH. HIGH and avg <= TH_LOW -> level_reg <= LOW. Otherwise hold.
  - Next state ACCUM.
  - If frame_valid arrives during EVAL, it becomes the first sample of the new window: acc <= car_count, frm_cnt <= 1. Otherwise acc <= 0, frm_cnt <= 0.
- Commit, on tr_valid:
  - traffic_sel <= level_reg.
  - Counts <= HIGH or LOW parameter pair per level_reg.
  - Counts change at the FSM's counter-zero point only; no other path modifies outputs.
- Simultaneous tr_valid and EVAL: the commit uses level_reg before the edge (old decision). The new decision waits for the next tr_valid, and decision_pending rises.
- decision_pending is registered: (level_reg_next != traffic_sel_next).
- Latency:
  - Last frame of the window -> density_avg/level_reg updated 2 edges later.
  - Outputs follow at the next tr_valid.

Optional Feature:
- Macro: TRAFFIC_FORCE_EN.
- Defined:
  - Adds ports force_en (in, 1) and force_sel (in, 1).
  - While force_en == 1, a tr_valid commit uses force_sel instead of level_reg (with the matching count pair).
  - Averaging and hysteresis continue undisturbed.
  - decision_pending compares against force_sel while forced.
- Undefined: ports absent; commit always uses level_reg.

Decomposition:
- Package traffic_pkg holds:
  - typedef enum {LOW, HIGH} density_t
  - typedef enum {ACCUM, EVAL} dens_state_t
  - localparam CNT5_W = 5 (FSM count width)
- Sub-module density_window_avg: accumulator, frame counter and average. Outputs avg plus a one-cycle avg_valid.
- Top module holds the hysteresis, commit registers and optional force logic.

Test Plan:
- Reset check: reset = 0 for 2 cycles -> traffic_sel = 0, red = 10, green = 10, density_avg = 0, decision_pending = 0.
- Rising density, no commit yet: 4 frames of car_count = 25 -> density_avg = 25 two edges after the 4th frame, decision_pending = 1, traffic_sel still 0.
- Commit: then tr_valid pulse -> traffic_sel = 1, red = 5, green = 20 next edge, decision_pending = 0.
- Hysteresis hold: in HIGH, window {15,15,14,14} -> avg = 14 > TH_LOW, stays HIGH. Window {12,12,12,13} -> avg = 12, goes LOW. After tr_valid -> red = 10, green = 10.
- Coincident events: tr_valid in the same cycle as EVAL with new level HIGH -> commit keeps old LOW, decision_pending = 1. Next tr_valid -> HIGH.
- Frame during EVAL plus reset mid-window:
  - frame_valid(count = 30) during EVAL -> the next window needs only 3 more frames; that 30 is included in the sum.
  - reset after 2 frames -> a window then needs 4 fresh frames.

Source files
------------

// File: rtl/traffic_density_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared types and constants for the traffic density controller
//               (density level, window-averager state, FSM count width).
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

  // Density classification handed to the traffic-light FSM
  typedef enum logic [0:0] {
    LOW  = 1'b0,
    HIGH = 1'b1
  } density_t;

  // Window averager: collect frames, then one evaluation cycle
  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    EVAL  = 1'b1
  } dens_state_t;

  // Width of the red/green second counts consumed by the FSM
  localparam int CNT5_W = 5;

endpackage
`default_nettype wire

// File: rtl/traffic_density_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : traffic_density_ctrl_if
// Description : Bundle between the video pipeline / traffic FSM (master) and
//               the density controller (slave). Optional macro
//               TRAFFIC_FORCE_EN adds the force_en / force_sel override pair.
// Revision    : 1.0 - initial release
// ============================================================================
interface traffic_density_ctrl_if #(
  parameter int CNT_W = 8
);
  import traffic_pkg::*;

`ifdef TRAFFIC_FORCE_EN
  logic                force_en;
  logic                force_sel;
`endif
  logic                frame_valid;
  logic [CNT_W-1:0]    car_count;
  logic                tr_valid;
  logic                traffic_sel;
  logic [CNT5_W-1:0]   howmany_count_red;
  logic [CNT5_W-1:0]   howmany_count_green;
  logic [CNT_W-1:0]    density_avg;
  logic                decision_pending;

  modport master (
`ifdef TRAFFIC_FORCE_EN
    output force_en,
    output force_sel,
`endif
    output frame_valid,
    output car_count,
    output tr_valid,
    input  traffic_sel,
    input  howmany_count_red,
    input  howmany_count_green,
    input  density_avg,
    input  decision_pending
  );

  modport slave (
`ifdef TRAFFIC_FORCE_EN
    input  force_en,
    input  force_sel,
`endif
    input  frame_valid,
    input  car_count,
    input  tr_valid,
    output traffic_sel,
    output howmany_count_red,
    output howmany_count_green,
    output density_avg,
    output decision_pending
  );

endinterface
`default_nettype wire

// File: rtl/traffic_density_ctrl_window_avg.sv
`default_nettype none
// ============================================================================
// Module      : density_window_avg
// Description : Sums 2^WIN_LOG2 per-frame vehicle counts, then spends one
//               EVAL cycle presenting the truncated average (avg_valid_o).
//               A frame arriving during EVAL opens the next window.
// Revision    : 1.0 - initial release
// ============================================================================
module density_window_avg
  import traffic_pkg::*;
#(
  parameter int WIN_LOG2 = 2,
  parameter int CNT_W    = 8
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             frame_valid_i,
  input  wire logic [CNT_W-1:0] car_count_i,
  output logic      [CNT_W-1:0] avg_o,
  output logic                  avg_valid_o
);

  // Sum of a full window of maximum counts fits without overflow
  localparam int ACC_W = CNT_W + WIN_LOG2;
  localparam logic [WIN_LOG2-1:0] c_last_frm = '1;
  localparam logic [WIN_LOG2-1:0] c_one_frm  = WIN_LOG2'(1);

  logic [ACC_W-1:0]    acc_q;
  logic [WIN_LOG2-1:0] frm_cnt_q;
  dens_state_t         state_q;
  logic [ACC_W-1:0]    w_cnt_ext;

  assign w_cnt_ext = {{WIN_LOG2{1'b0}}, car_count_i};

  // Window FSM: accumulate frames, then a single evaluation cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q     <= '0;
      frm_cnt_q <= '0;
      state_q   <= ACCUM;
    end else begin
      case (state_q)
        ACCUM: begin
          if (frame_valid_i) begin
            acc_q     <= acc_q + w_cnt_ext;
            frm_cnt_q <= frm_cnt_q + 1'b1;
            if (frm_cnt_q == c_last_frm) begin
              state_q <= EVAL;
            end
          end
        end
        EVAL: begin
          state_q <= ACCUM;
          if (frame_valid_i) begin
            acc_q     <= w_cnt_ext;
            frm_cnt_q <= c_one_frm;
          end else begin
            acc_q     <= '0;
            frm_cnt_q <= '0;
          end
        end
        default: begin
          state_q <= ACCUM;
        end
      endcase
    end
  end

  // Truncating divide by the window length is a plain bit slice
  assign avg_o       = acc_q[ACC_W-1:WIN_LOG2];
  assign avg_valid_o = (state_q == EVAL);

endmodule
`default_nettype wire

// File: rtl/traffic_density_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : traffic_density_ctrl
// Description : Classifies windowed vehicle density LOW/HIGH with hysteresis
//               and commits the decision (level + red/green seconds) to the
//               traffic FSM only on its tr_valid pulse.
//               Optional macro TRAFFIC_FORCE_EN: force_en/force_sel override
//               the committed level.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_density_ctrl
  import traffic_pkg::*;
#(
  parameter int WIN_LOG2     = 2,
  parameter int CNT_W        = 8,
  parameter int TH_HIGH      = 20,
  parameter int TH_LOW       = 12,
  parameter int RED_T_LOW    = 10,
  parameter int GREEN_T_LOW  = 10,
  parameter int RED_T_HIGH   = 5,
  parameter int GREEN_T_HIGH = 20
) (
  input  wire logic          clk,
  input  wire logic          reset,
  traffic_density_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0]  c_th_high  = CNT_W'(TH_HIGH);
  localparam logic [CNT_W-1:0]  c_th_low   = CNT_W'(TH_LOW);
  localparam logic [CNT5_W-1:0] c_red_low  = CNT5_W'(RED_T_LOW);
  localparam logic [CNT5_W-1:0] c_grn_low  = CNT5_W'(GREEN_T_LOW);
  localparam logic [CNT5_W-1:0] c_red_high = CNT5_W'(RED_T_HIGH);
  localparam logic [CNT5_W-1:0] c_grn_high = CNT5_W'(GREEN_T_HIGH);

  logic [CNT_W-1:0]  w_avg;
  logic              w_avg_valid;
  density_t          w_commit_sel;
  density_t          w_target;

  density_t          level_q,  level_d;
  density_t          sel_q,    sel_d;
  logic [CNT5_W-1:0] red_q,    red_d;
  logic [CNT5_W-1:0] grn_q,    grn_d;
  logic [CNT_W-1:0]  avg_q,    avg_d;
  logic              pend_q,   pend_d;

  density_window_avg #(
    .WIN_LOG2 (WIN_LOG2),
    .CNT_W    (CNT_W)
  ) u_window_avg (
    .clk           (clk),
    .reset         (reset),
    .frame_valid_i (bus.frame_valid),
    .car_count_i   (bus.car_count),
    .avg_o         (w_avg),
    .avg_valid_o   (w_avg_valid)
  );

  // Next-state: hysteresis on a fresh average, commit on tr_valid
  always_comb begin
    level_d = level_q;
    avg_d   = avg_q;
    if (w_avg_valid) begin
      avg_d = w_avg;
      if (level_q == LOW && w_avg >= c_th_high) begin
        level_d = HIGH;
      end else if (level_q == HIGH && w_avg <= c_th_low) begin
        level_d = LOW;
      end
    end

    // The commit samples level_q, so a coincident evaluation waits a turn
`ifdef TRAFFIC_FORCE_EN
    w_commit_sel = bus.force_en ? density_t'(bus.force_sel) : level_q;
    w_target     = bus.force_en ? density_t'(bus.force_sel) : level_d;
`else
    w_commit_sel = level_q;
    w_target     = level_d;
`endif

    sel_d = sel_q;
    red_d = red_q;
    grn_d = grn_q;
    if (bus.tr_valid) begin
      sel_d = w_commit_sel;
      red_d = (w_commit_sel == HIGH) ? c_red_high : c_red_low;
      grn_d = (w_commit_sel == HIGH) ? c_grn_high : c_grn_low;
    end

    pend_d = (w_target != sel_d);
  end

  // Decision and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      level_q <= LOW;
      sel_q   <= LOW;
      red_q   <= c_red_low;
      grn_q   <= c_grn_low;
      avg_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      sel_q   <= sel_d;
      red_q   <= red_d;
      grn_q   <= grn_d;
      avg_q   <= avg_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.traffic_sel         = (sel_q == HIGH);
  assign bus.howmany_count_red   = red_q;
  assign bus.howmany_count_green = grn_q;
  assign bus.density_avg         = avg_q;
  assign bus.decision_pending    = pend_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_density_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_density_ctrl
// Description : Self-checking bench for traffic_density_ctrl: directed vector
//               table for the documented scenarios, then randomized traffic
//               checked against a window-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_density_ctrl;

  localparam int WIN   = 4;
  localparam int TH_HI = 20;
  localparam int TH_LO = 12;

  typedef struct {
    logic       rn;
    logic       fv;
    logic [7:0] cc;
    logic       tv;
    logic       sel;
    logic [4:0] red;
    logic [4:0] grn;
    logic [7:0] avg;
    logic       pend;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl[$];

  // Reference model state
  int q_win[$];
  bit m_eval;
  bit m_level;
  bit m_sel;
  int m_avg;
  bit m_pend;

  traffic_density_ctrl_if #(.CNT_W(8)) bus ();

  traffic_density_ctrl #(
    .WIN_LOG2     (2),
    .CNT_W        (8),
    .TH_HIGH      (TH_HI),
    .TH_LOW       (TH_LO),
    .RED_T_LOW    (10),
    .GREEN_T_LOW  (10),
    .RED_T_HIGH   (5),
    .GREEN_T_HIGH (20)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a window is a list of counts; the cycle after it fills, it is averaged
  task automatic model_step(input bit rn, input bit fv, input int cc, input bit tv);
    bit old_level;
    int sum;
    if (!rn) begin
      q_win.delete();
      m_eval = 0; m_level = 0; m_sel = 0; m_avg = 0; m_pend = 0;
      return;
    end
    old_level = m_level;
    if (m_eval) begin
      sum = 0;
      foreach (q_win[k]) sum += q_win[k];
      m_avg = sum / WIN;
      if (!m_level && m_avg >= TH_HI) m_level = 1;
      else if (m_level && m_avg <= TH_LO) m_level = 0;
      q_win.delete();
      m_eval = 0;
      if (fv) q_win.push_back(cc);
    end else if (fv) begin
      q_win.push_back(cc);
      if (q_win.size() == WIN) m_eval = 1;
    end
    if (tv) m_sel = old_level;
    m_pend = (m_level != m_sel);
  endtask

  // Drive one cycle of inputs, advance past the edge, update the model
  task automatic step(input bit rn, input bit fv, input int cc, input bit tv);
    rst_n           = rn;
    bus.frame_valid = fv;
    bus.car_count   = 8'(cc);
    bus.tr_valid    = tv;
    @(posedge clk);
    #1;
    model_step(rn, fv, cc, tv);
    bus.frame_valid = 1'b0;
    bus.tr_valid    = 1'b0;
  endtask

  task automatic add(input bit rn, input bit fv, input int cc, input bit tv,
                     input bit sel, input int red, input int grn, input int avg, input bit pend);
    vec_t v;
    v.rn = rn; v.fv = fv; v.cc = 8'(cc); v.tv = tv;
    v.sel = sel; v.red = 5'(red); v.grn = 5'(grn); v.avg = 8'(avg); v.pend = pend;
    tbl.push_back(v);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_sel"},   int'(bus.traffic_sel),         int'(m_sel));
    chk({tag, "_red"},   int'(bus.howmany_count_red),   m_sel ? 5 : 10);
    chk({tag, "_green"}, int'(bus.howmany_count_green), m_sel ? 20 : 10);
    chk({tag, "_avg"},   int'(bus.density_avg),         m_avg);
    chk({tag, "_pend"},  int'(bus.decision_pending),    int'(m_pend));
  endtask

  initial begin
    int bias_hi;
    rst_n           = 1'b0;
    bus.frame_valid = 1'b0;
    bus.car_count   = '0;
    bus.tr_valid    = 1'b0;
`ifdef TRAFFIC_FORCE_EN
    bus.force_en    = 1'b0;
    bus.force_sel   = 1'b0;
`endif

    // rn fv cc tv | sel red grn avg pend
    add(0, 0,  0, 0,  0, 10, 10,  0, 0);   // reset
    add(0, 0,  0, 0,  0, 10, 10,  0, 0);
    for (int i = 0; i < 4; i++) add(1, 1, 25, 0,  0, 10, 10, 0, 0);
    add(1, 0,  0, 0,  0, 10, 10, 25, 1);   // evaluated, not committed
    add(1, 0,  0, 1,  1,  5, 20, 25, 0);   // commit HIGH
    add(1, 1, 15, 0,  1,  5, 20, 25, 0);
    add(1, 1, 15, 0,  1,  5, 20, 25, 0);
    add(1, 1, 14, 0,  1,  5, 20, 25, 0);
    add(1, 1, 14, 0,  1,  5, 20, 25, 0);
    add(1, 0,  0, 0,  1,  5, 20, 14, 0);   // 14 > TH_LOW: stays HIGH
    add(1, 1, 12, 0,  1,  5, 20, 14, 0);
    add(1, 1, 12, 0,  1,  5, 20, 14, 0);
    add(1, 1, 12, 0,  1,  5, 20, 14, 0);
    add(1, 1, 13, 0,  1,  5, 20, 14, 0);
    add(1, 0,  0, 0,  1,  5, 20, 12, 1);   // 12 <= TH_LOW: goes LOW
    add(1, 0,  0, 1,  0, 10, 10, 12, 0);
    for (int i = 0; i < 4; i++) add(1, 1, 30, 0,  0, 10, 10, 12, 0);
    add(1, 0,  0, 1,  0, 10, 10, 30, 1);   // tr_valid during EVAL: old LOW kept
    add(1, 0,  0, 1,  1,  5, 20, 30, 0);
    for (int i = 0; i < 4; i++) add(1, 1, 0, 0,  1,  5, 20, 30, 0);
    add(1, 1, 30, 0,  1,  5, 20,  0, 1);   // frame during EVAL starts window
    for (int i = 0; i < 3; i++) add(1, 1, 30, 0,  1, 5, 20, 0, 1);
    add(1, 0,  0, 0,  1,  5, 20, 30, 0);   // 4-frame window incl. the EVAL frame
    add(1, 1, 30, 0,  1,  5, 20, 30, 0);
    add(1, 1, 30, 0,  1,  5, 20, 30, 0);
    add(0, 0,  0, 0,  0, 10, 10,  0, 0);   // reset mid-window
    for (int i = 0; i < 3; i++) add(1, 1, 30, 0,  0, 10, 10, 0, 0);
    add(1, 0,  0, 0,  0, 10, 10,  0, 0);   // only 3 frames: no evaluation
    add(1, 1, 30, 0,  0, 10, 10,  0, 0);
    add(1, 0,  0, 0,  0, 10, 10, 30, 1);

    foreach (tbl[i]) begin
      step(tbl[i].rn, tbl[i].fv, int'(tbl[i].cc), tbl[i].tv);
      chk($sformatf("vec%0d_sel", i),   int'(bus.traffic_sel),         int'(tbl[i].sel));
      chk($sformatf("vec%0d_red", i),   int'(bus.howmany_count_red),   int'(tbl[i].red));
      chk($sformatf("vec%0d_green", i), int'(bus.howmany_count_green), int'(tbl[i].grn));
      chk($sformatf("vec%0d_avg", i),   int'(bus.density_avg),         int'(tbl[i].avg));
      chk($sformatf("vec%0d_pend", i),  int'(bus.decision_pending),    int'(tbl[i].pend));
    end

    // Randomized traffic against the reference model
    step(0, 0, 0, 0);
    check_model("rst");
    bias_hi = 0;
    for (int c = 0; c < 3000; c++) begin
      bit rn, fv, tv;
      int cc;
      if (c % 48 == 0) bias_hi = int'($urandom_range(0, 1));
      rn = ($urandom_range(0, 199) != 0);
      fv = ($urandom_range(0, 1) == 1);
      cc = bias_hi ? int'($urandom_range(16, 45)) : int'($urandom_range(0, 18));
      if (!fv && $urandom_range(0, 3) == 0) cc = 255;  // ignored without frame_valid
      tv = ($urandom_range(0, 7) == 0);
      step(rn, fv, cc, tv);
      check_model("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
